// File: rtl/yu_pkg.sv
// Shared encodings for the multi-cycle Yu Core datapath.
package yu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
    } alu_op_t;

    typedef enum logic [1:0] {
        HC_NONE, HC_ILLEGAL, HC_MIS_FETCH, HC_MIS_LS
    } halt_cause_t;

    // funct3 values that name an implemented register/immediate ALU op
    function automatic logic f3_is_alu(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
               (f3 == F3_OR)  || (f3 == F3_AND);
    endfunction

    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic sub);
        case (f3)
            F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
            F3_SLT:  return ALU_SLT;
            F3_XOR:  return ALU_XOR;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/yu_mc_alu.sv
// Combinational ALU: arithmetic/logic result plus operand equality flag for branches.
module yu_mc_alu
    import yu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_t         i_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_eq
);

    // result select; SLT is a signed compare zero-extended to XLEN
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SLT: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_result = '0;
        endcase
    end

    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/multi_cycle_datapath.sv
// Multi-cycle RV32I-subset core: FSM, PC, register file, IR/A/B/ALU-out latches, shared memory port.
//
// state        | meaning
// ST_FETCH     | request instruction at PC, latch IR on ready
// ST_DECODE    | read rs1/rs2 into A/B, reject illegal encodings
// ST_EXECUTE   | compute ALU-out and next PC, check load/store alignment
// ST_MEM       | load/store data transfer at ALU-out
// ST_WRITEBACK | write rd, update PC, pulse retire
// ST_HALT      | stopped on a fault until reset
module multi_cycle_datapath
    import yu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            retire,
    output logic            halted,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] pc
);

    localparam int RW = $clog2(NUM_REGS);

    state_t          r_state, w_state_nxt;
    halt_cause_t     r_halt_cause, w_cause_nxt;
    logic [XLEN-1:0] r_pc, r_a, r_b, r_alu_out, r_next_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_rf [NUM_REGS];

    logic [6:0] w_opcode, w_f7;
    logic [2:0] w_f3;
    logic [4:0] w_rd, w_rs1, w_rs2;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    assign w_imm_i = XLEN'($signed(r_ir[31:20]));
    assign w_imm_s = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
    assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
    assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
    assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));

    logic            w_legal, w_writes_rd, w_use_rs1, w_use_rs2, w_use_imm;
    logic            w_is_lui, w_is_load, w_is_store, w_is_branch, w_is_jal;
    alu_op_t         w_alu_op;
    logic [XLEN-1:0] w_imm;

    // instruction decode from the latched IR; IR is stable from DECODE to WRITEBACK
    always_comb begin
        w_legal     = 1'b0;
        w_writes_rd = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_use_imm   = 1'b0;
        w_is_lui    = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_alu_op    = ALU_ADD;
        w_imm       = '0;
        case (w_opcode)
            OP_LUI: begin
                w_legal = 1'b1; w_writes_rd = 1'b1; w_is_lui = 1'b1; w_imm = w_imm_u;
            end
            OP_IMM: begin
                w_legal = f3_is_alu(w_f3); w_writes_rd = 1'b1; w_use_rs1 = 1'b1;
                w_use_imm = 1'b1; w_imm = w_imm_i; w_alu_op = alu_op_from_f3(w_f3, 1'b0);
            end
            OP_REG: begin
                w_legal = ((w_f7 == F7_BASE) && f3_is_alu(w_f3)) ||
                          ((w_f7 == F7_SUB) && (w_f3 == F3_ADD));
                w_writes_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_alu_op = alu_op_from_f3(w_f3, w_f7 == F7_SUB);
            end
            OP_LOAD: begin
                w_legal = (w_f3 == F3_W); w_writes_rd = 1'b1; w_use_rs1 = 1'b1;
                w_use_imm = 1'b1; w_imm = w_imm_i; w_is_load = 1'b1;
            end
            OP_STORE: begin
                w_legal = (w_f3 == F3_W); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_use_imm = 1'b1; w_imm = w_imm_s; w_is_store = 1'b1;
            end
            OP_BRANCH: begin
                w_legal = (w_f3 == F3_BEQ) || (w_f3 == F3_BNE);
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_b;
                w_alu_op = ALU_SUB; w_is_branch = 1'b1;
            end
            OP_JAL: begin
                w_legal = 1'b1; w_writes_rd = 1'b1; w_imm = w_imm_j; w_is_jal = 1'b1;
            end
            default: ;
        endcase
    end

    function automatic logic reg_ok(input logic [4:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    // only fields the instruction actually uses are range-checked (matters for RV32E)
    logic w_regs_ok;
    assign w_regs_ok = (!w_writes_rd || reg_ok(w_rd)) &&
                       (!w_use_rs1   || reg_ok(w_rs1)) &&
                       (!w_use_rs2   || reg_ok(w_rs2));

    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1[RW-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2[RW-1:0]];

    logic [XLEN-1:0] w_alu_res;
    logic            w_eq;

    yu_mc_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (r_a),
        .i_b      (w_use_imm ? w_imm : r_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_res),
        .o_eq     (w_eq)
    );

    logic            w_taken, w_ls_misaligned;
    logic [XLEN-1:0] w_pc_plus4, w_pc_imm;
    assign w_taken         = (w_f3 == F3_BNE) ? !w_eq : w_eq;
    assign w_ls_misaligned = (w_alu_res[1:0] != 2'b00);
    assign w_pc_plus4      = r_pc + XLEN'(4);
    assign w_pc_imm        = r_pc + w_imm;

    // next-state and halt-cause selection
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = HC_NONE;
        case (r_state)
            ST_FETCH: begin
                if (r_pc[1:0] != 2'b00) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = HC_MIS_FETCH;
                end else if (mem_ready) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!(w_legal && w_regs_ok)) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = HC_ILLEGAL;
                end else begin
                    w_state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (w_is_load || w_is_store) begin
                    if (w_ls_misaligned) begin
                        w_state_nxt = ST_HALT;
                        w_cause_nxt = HC_MIS_LS;
                    end else begin
                        w_state_nxt = ST_MEM;
                    end
                end else begin
                    w_state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEM:       if (mem_ready) w_state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: w_state_nxt = ST_FETCH;
            default:      w_state_nxt = ST_HALT;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_state_nxt;
    end

    // datapath latches, register file and PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_out    <= '0;
            r_next_pc    <= '0;
            r_halt_cause <= HC_NONE;
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                ST_FETCH: if (mem_ready && r_pc[1:0] == 2'b00) r_ir <= mem_rdata[31:0];
                ST_DECODE: begin
                    r_a <= w_rs1_val;
                    r_b <= w_rs2_val;
                end
                ST_EXECUTE: begin
                    r_alu_out <= w_is_lui ? w_imm : (w_is_jal ? w_pc_plus4 : w_alu_res);
                    r_next_pc <= (w_is_jal || (w_is_branch && w_taken)) ? w_pc_imm : w_pc_plus4;
                end
                ST_MEM: if (mem_ready && w_is_load) r_alu_out <= XLEN'($signed(mem_rdata[31:0]));
                ST_WRITEBACK: begin
                    if (w_writes_rd && w_rd != 5'd0) r_rf[w_rd[RW-1:0]] <= r_alu_out;
                    r_pc <= r_next_pc;
                end
                default: ;
            endcase
            if (r_state != ST_HALT && w_state_nxt == ST_HALT) r_halt_cause <= w_cause_nxt;
        end
    end

    // a misaligned PC never raises a request; reset forces the strobes low
    assign mem_req    = !rst && (((r_state == ST_FETCH) && (r_pc[1:0] == 2'b00)) || (r_state == ST_MEM));
    assign mem_we     = !rst && (r_state == ST_MEM) && w_is_store;
    assign mem_addr   = (r_state == ST_MEM) ? r_alu_out : r_pc;
    assign mem_wdata  = r_b;
    assign retire     = !rst && (r_state == ST_WRITEBACK);
    assign halted     = (r_state == ST_HALT);
    assign halt_cause = r_halt_cause;
    assign pc         = r_pc;

endmodule

// File: tb/tb_multi_cycle_datapath.sv
// Directed bench for multi_cycle_datapath with a word-addressed memory model.
module tb_multi_cycle_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [1:0]  halt_cause;

    multi_cycle_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .retire     (retire),
        .halted     (halted),
        .halt_cause (halt_cause),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // memory model: fetches below 0x100 have zero wait; the data region gets data_wait or stalls
    logic [31:0] mem [256];
    int          wcnt = 0;
    int          data_wait = 0;
    logic        stuck = 1'b0;
    int          cyc = 0;
    int          ret_q[$];
    logic [31:0] bad_addr = 32'hFFFF_FFFF;
    logic        saw_bad = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          c0 = 0;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = (mem_addr >= 32'h100) ? (!stuck && wcnt >= data_wait) : 1'b1;

    always @(posedge clk) begin
        if (!mem_req || mem_ready) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (retire) ret_q.push_back(cyc);
        if (mem_req && mem_addr == bad_addr) saw_bad = 1'b1;
        if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ret_q.delete();
        data_wait = 0;
        stuck     = 1'b0;
        bad_addr  = 32'hFFFF_FFFF;
        saw_bad   = 1'b0;
    endtask

    task automatic end_reset(input string tag);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rst_req"}, mem_req, 1'b0);
        check({tag, "_rst_retire"}, retire, 1'b0);
        check({tag, "_rst_halted"}, halted, 1'b0);
        check({tag, "_rst_cause"}, halt_cause, 2'd0);
        check({tag, "_rst_pc"}, pc, 32'h0);
        rst = 1'b0;
        c0  = cyc;
        #1;
        check({tag, "_first_req"}, mem_req, 1'b1);
        check({tag, "_first_addr"}, mem_addr, 32'h0);
        check({tag, "_first_we"}, mem_we, 1'b0);
    endtask

    task automatic wait_ret(input string tag, input int n);
        int k = 0;
        while (ret_q.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_retire_timeout"}, ret_q.size() >= n, 1'b1);
    endtask

    task automatic wait_halt(input string tag);
        int k = 0;
        while (!halted && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_halted"}, halted, 1'b1);
    endtask

    task automatic wait_store(input string tag);
        int k = 0;
        while (!(mem_req && mem_we) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_store_seen"}, mem_req && mem_we, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ALU chain: ADDI/ADD timing plus the remaining ALU ops and LUI
        begin_reset();
        mem[0]  = enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'd5);
        mem[1]  = enc_r(7'h00, 5'd2, 3'b000, 5'd1, 5'd1);
        mem[2]  = enc_i(7'h13, 5'd3, 3'b000, 5'd0, 32'hFFFF_FFFD);
        mem[3]  = enc_r(7'h00, 5'd4, 3'b010, 5'd3, 5'd1);
        mem[4]  = enc_r(7'h20, 5'd5, 3'b000, 5'd1, 5'd2);
        mem[5]  = enc_i(7'h13, 5'd6, 3'b100, 5'd1, 32'h0F);
        mem[6]  = {20'h12345, 5'd7, 7'h37};
        mem[7]  = enc_i(7'h13, 5'd8, 3'b010, 5'd1, 32'hFFFF_FFFF);
        mem[8]  = enc_r(7'h00, 5'd9, 3'b111, 5'd3, 5'd1);
        mem[9]  = enc_r(7'h00, 5'd10, 3'b110, 5'd2, 5'd1);
        mem[10] = enc_i(7'h13, 5'd11, 3'b111, 5'd2, 32'd6);
        mem[11] = enc_r(7'h00, 5'd12, 3'b100, 5'd1, 5'd2);
        mem[12] = enc_j(5'd0, 32'd0);
        end_reset("alu");
        wait_ret("alu", 2);
        check("alu_first_retire_cyc", ret_q[0] - c0, 4);
        check("alu_retire_spacing", ret_q[1] - ret_q[0], 4);
        check("alu_pc_after_2", pc, 32'h8);
        check("alu_x2", dut.r_rf[2], 32'd10);
        wait_ret("alu12", 12);
        check("alu_pc_after_12", pc, 32'h30);
        check("alu_x1", dut.r_rf[1], 32'd5);
        check("alu_x3", dut.r_rf[3], 32'hFFFF_FFFD);
        check("alu_slt", dut.r_rf[4], 32'd1);
        check("alu_sub", dut.r_rf[5], 32'hFFFF_FFFB);
        check("alu_xori", dut.r_rf[6], 32'h0A);
        check("alu_lui", dut.r_rf[7], 32'h1234_5000);
        check("alu_slti", dut.r_rf[8], 32'd0);
        check("alu_and", dut.r_rf[9], 32'd5);
        check("alu_or", dut.r_rf[10], 32'h0F);
        check("alu_andi", dut.r_rf[11], 32'd2);
        check("alu_xor", dut.r_rf[12], 32'h0F);

        // SW/LW with three data wait states
        begin_reset();
        data_wait = 3;
        mem[0] = enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'h100);
        mem[1] = enc_s(5'd1, 5'd1, 32'd0);
        mem[2] = enc_i(7'h03, 5'd2, 3'b010, 5'd1, 32'd0);
        mem[3] = enc_j(5'd0, 32'd0);
        end_reset("ls");
        wait_ret("ls", 1);
        wait_store("ls");
        for (int i = 0; i < 4; i++) begin
            check("ls_sw_req", mem_req, 1'b1);
            check("ls_sw_addr", mem_addr, 32'h100);
            check("ls_sw_wdata", mem_wdata, 32'h100);
            @(negedge clk);
        end
        wait_ret("ls", 3);
        check("ls_addi_cyc", ret_q[0] - c0, 4);
        check("ls_sw_cycles", ret_q[1] - ret_q[0], 8);
        check("ls_lw_cycles", ret_q[2] - ret_q[1], 8);
        check("ls_mem_word", mem[64], 32'h100);
        check("ls_x2", dut.r_rf[2], 32'h100);

        // BEQ taken backwards, then BNE not taken at the same PC
        for (int br = 0; br < 2; br++) begin
            begin_reset();
            mem[0] = enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'd7);
            mem[1] = enc_i(7'h13, 5'd2, 3'b000, 5'd0, 32'd7);
            mem[2] = enc_j(5'd0, 32'h18);
            mem[6] = enc_j(5'd0, 32'd0);
            mem[8] = enc_b((br == 0) ? 3'b000 : 3'b001, 5'd1, 5'd2, 32'hFFFF_FFF8);
            mem[9] = enc_j(5'd0, 32'd0);
            end_reset("br");
            wait_ret("br", 3);
            check("br_jal_pc", pc, 32'h20);
            wait_ret("br", 4);
            check("br_pc", pc, (br == 0) ? 32'h18 : 32'h24);
            check("br_fetch_addr", mem_addr, (br == 0) ? 32'h18 : 32'h24);
        end

        // JAL with rd=x0 and rd=x1 at PC 0x10
        for (int j = 0; j < 2; j++) begin
            begin_reset();
            mem[0]  = enc_j(5'd0, 32'h10);
            mem[4]  = enc_j((j == 0) ? 5'd0 : 5'd1, 32'h40);
            mem[20] = enc_j(5'd0, 32'd0);
            end_reset("jal");
            wait_ret("jal", 2);
            check("jal_pc", pc, 32'h50);
            check("jal_fetch_addr", mem_addr, 32'h50);
            check("jal_x0", dut.r_rf[0], 32'h0);
            check("jal_x1", dut.r_rf[1], (j == 0) ? 32'h0 : 32'h14);
        end

        // misaligned load
        begin_reset();
        bad_addr = 32'h102;
        mem[0] = enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'h102);
        mem[1] = enc_i(7'h03, 5'd2, 3'b010, 5'd1, 32'd0);
        end_reset("mis_ls");
        wait_halt("mis_ls");
        check("mis_ls_cause", halt_cause, 2'd3);
        check("mis_ls_pc", pc, 32'h4);
        check("mis_ls_req", mem_req, 1'b0);
        repeat (5) @(negedge clk);
        check("mis_ls_still_halted", halted, 1'b1);
        check("mis_ls_no_req_102", saw_bad, 1'b0);
        check("mis_ls_retires", ret_q.size(), 1);

        // illegal opcode 0x7F and illegal funct3 (SLLI)
        for (int il = 0; il < 2; il++) begin
            begin_reset();
            mem[0] = (il == 0) ? 32'h0000_007F : enc_i(7'h13, 5'd1, 3'b001, 5'd0, 32'd1);
            end_reset("illegal");
            wait_halt("illegal");
            check("illegal_cause", halt_cause, 2'd1);
            check("illegal_pc", pc, 32'h0);
            check("illegal_retires", ret_q.size(), 0);
        end

        // misaligned fetch after JAL +2
        begin_reset();
        bad_addr = 32'h2;
        mem[0] = enc_j(5'd0, 32'd2);
        end_reset("mis_f");
        wait_halt("mis_f");
        check("mis_f_cause", halt_cause, 2'd2);
        check("mis_f_pc", pc, 32'h2);
        check("mis_f_no_req", saw_bad, 1'b0);
        check("mis_f_retires", ret_q.size(), 1);

        // reset in the middle of a stalled store
        begin_reset();
        stuck = 1'b1;
        mem[0] = enc_i(7'h13, 5'd1, 3'b000, 5'd0, 32'h100);
        mem[1] = enc_s(5'd1, 5'd1, 32'd0);
        end_reset("abort");
        wait_ret("abort", 1);
        wait_store("abort");
        repeat (3) @(negedge clk);
        check("abort_store_pending", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_req_forced", mem_req, 1'b0);
        check("abort_we_forced", mem_we, 1'b0);
        check("abort_retire_forced", retire, 1'b0);
        @(negedge clk);
        check("abort_x1_cleared", dut.r_rf[1], 32'h0);
        check("abort_no_write", mem[64], 32'h0);
        check("abort_retires", ret_q.size(), 1);
        end_reset("abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
